// File: rtl/vram_scan_fetch.sv
// VRAM port-B scan fetcher: programs a start address and stride, then streams words into a prefetch FIFO.
// Optional build macro VRAM_FETCH_UNDERRUN_EN adds a sticky underrun detector.
module vram_scan_fetch #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] base_addr,
    input  logic [15:0] stride,
    input  logic [15:0] word_count,
    inout  wire  [15:0] data_bus_infr,
    output logic        set_address_b,
    output logic        set_address_b_incr,
    output logic        read_b,
    output logic [15:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        busy,
    output logic        done,
    output logic        underrun
);

    // state | meaning
    // IDLE  | waiting for start
    // SETA  | base address on bus, set_address_b strobe
    // SETI  | stride on bus, set_address_b_incr strobe
    // READ  | issue read_b while FIFO has room and words remain
    // DRAIN | all reads issued, wait for FIFO to empty
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SETA  = 3'd1;
    localparam logic [2:0] SETI  = 3'd2;
    localparam logic [2:0] READ  = 3'd3;
    localparam logic [2:0] DRAIN = 3'd4;

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [2:0]    state_q, state_d;
    logic [15:0]   base_q, stride_q, remaining_q;
    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_q;
    logic          start_acc, push, pop;

    assign start_acc          = start && (state_q == IDLE);
    assign set_address_b      = (state_q == SETA);
    assign set_address_b_incr = (state_q == SETI);
    assign read_b             = (state_q == READ) && (count_q < CW'(DEPTH)) && (remaining_q != 16'd0);
    assign busy               = (state_q != IDLE);
    assign pix_valid          = (count_q != '0);
    assign done               = (state_q == DRAIN) && !pix_valid;
    assign pix_data           = pix_valid ? mem[rd_ptr] : 16'd0;
    assign push               = read_b;
    assign pop                = pix_valid && pix_ready;

    assign data_bus_infr = (state_q == SETA) ? base_q   :
                           (state_q == SETI) ? stride_q : 16'bz;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (word_count == 16'd0) ? DRAIN : SETA;
            SETA:    state_d = SETI;
            SETI:    state_d = READ;
            READ:    if (read_b && remaining_q == 16'd1) state_d = DRAIN;
            DRAIN:   if (!pix_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            base_q      <= 16'd0;
            stride_q    <= 16'd0;
            remaining_q <= 16'd0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
        end else begin
            state_q <= state_d;
            if (start_acc) begin
                base_q      <= base_addr;
                stride_q    <= stride;
                remaining_q <= word_count;
            end else if (read_b) begin
                remaining_q <= remaining_q - 16'd1;
            end
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count_q <= count_q + CW'(1);
            else if (pop && !push) count_q <= count_q - CW'(1);
        end
    end

    // FIFO storage needs no reset: emptiness is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data_bus_infr;
    end

`ifdef VRAM_FETCH_UNDERRUN_EN
    logic underrun_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                          underrun_q <= 1'b0;
        else if (start_acc)                                  underrun_q <= 1'b0;
        else if (state_q == READ && pix_ready && !pix_valid) underrun_q <= 1'b1;
    end
    assign underrun = underrun_q;
`else
    assign underrun = 1'b0;
`endif

endmodule

// File: tb/tb_vram_scan_fetch.sv
// Self-checking bench for vram_scan_fetch with a behavioural VRAM port-B model and expected-stream model.
module tb_vram_scan_fetch;
    localparam int DEPTH = 8;
    localparam logic [15:0] KEY = 16'h5A3C;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] base_addr = 16'd0, stride = 16'd0, word_count = 16'd0;
    wire  [15:0] data_bus_infr;
    logic        set_address_b, set_address_b_incr, read_b;
    logic [15:0] pix_data;
    logic        pix_valid, busy, done, underrun;
    logic        pix_ready = 1'b0;

    vram_scan_fetch #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .stride(stride),
        .word_count(word_count), .data_bus_infr(data_bus_infr), .set_address_b(set_address_b),
        .set_address_b_incr(set_address_b_incr), .read_b(read_b), .pix_data(pix_data),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .busy(busy), .done(done), .underrun(underrun)
    );

    always #5 clk = ~clk;

    // VRAM port-B model: address register with auto-increment, returns addr ^ KEY on reads.
    logic [15:0] vaddr = 16'd0, vinc = 16'd0;
    assign data_bus_infr = read_b ? (vaddr ^ KEY) : 16'bz;
    always @(posedge clk) begin
        if (set_address_b)      vaddr <= data_bus_infr;
        if (set_address_b_incr) vinc  <= data_bus_infr;
        if (read_b)             vaddr <= vaddr + vinc;
    end

    int checks = 0, errors = 0;
    int n_read = 0, n_done = 0, n_seta = 0, n_overlap = 0;
    logic [15:0] obs_q[$];
    logic        s_seta, s_incr, s_read, s_valid, s_busy, s_done, s_under;
    logic [15:0] s_bus, s_data;

    function automatic logic [15:0] exp_word(logic [15:0] b, logic [15:0] s, int i);
        logic [15:0] idx;
        idx = 16'(i);
        return (b + idx * s) ^ KEY;
    endfunction

    // Sample at negedge, then return just after the next rising edge where inputs may change.
    task automatic tick();
        @(negedge clk);
        s_seta = set_address_b; s_incr = set_address_b_incr; s_read = read_b;
        s_bus = data_bus_infr; s_valid = pix_valid; s_data = pix_data;
        s_busy = busy; s_done = done; s_under = underrun;
        if (reset) begin
            if (read_b) n_read++;
            if (done) n_done++;
            if (set_address_b) n_seta++;
            if (32'(set_address_b) + 32'(set_address_b_incr) + 32'(read_b) > 1) n_overlap++;
            if (pix_valid && pix_ready) obs_q.push_back(pix_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic start_scan(input logic [15:0] b, input logic [15:0] s, input logic [15:0] w);
        obs_q.delete();
        start = 1'b1; base_addr = b; stride = s; word_count = w;
        tick();
        start = 1'b0;
        base_addr = 16'($urandom); stride = 16'($urandom); word_count = 16'($urandom);
    endtask

    task automatic wait_done(input int budget, input bit rnd, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            if (rnd) pix_ready = 1'($urandom_range(0, 1));
            tick();
            if (s_done) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        tick();
        checks++;
        if ({s_seta, s_incr, s_read, s_valid, s_busy, s_done, s_under} !== 7'b0 || s_data !== 16'd0) begin
            errors++;
            $display("FAIL reset_values: got strobes/flags=%b data=%h, want all 0", {s_seta, s_incr, s_read, s_valid, s_busy, s_done, s_under}, s_data);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (s_busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy=%b want 0", s_busy); end
    endtask

    task automatic test_basic();
        int r0, d0;
        bit seen;
        r0 = n_read; d0 = n_done;
        pix_ready = 1'b1;
        start_scan(16'd2332, 16'd1, 16'd4);
        tick();
        checks++;
        if (!(s_seta && !s_incr && !s_read && s_bus === 16'd2332 && s_busy)) begin
            errors++; $display("FAIL basic_seta: seta=%b bus=%0d busy=%b want 1/2332/1", s_seta, s_bus, s_busy);
        end
        tick();
        checks++;
        if (!(s_incr && !s_seta && !s_read && s_bus === 16'd1)) begin
            errors++; $display("FAIL basic_seti: incr=%b bus=%0d want 1/1", s_incr, s_bus);
        end
        tick();
        checks++;
        if (s_read !== 1'b1) begin errors++; $display("FAIL basic_first_read: read_b=%b want 1", s_read); end
        tick();
        checks++;
        if (s_valid !== 1'b1) begin errors++; $display("FAIL basic_first_valid: pix_valid=%b want 1", s_valid); end
        wait_done(50, 1'b0, seen);
        checks++;
        if (!seen) begin errors++; $display("FAIL basic_timeout: done not seen, want done"); end
        checks++;
        if (n_read - r0 != 4) begin errors++; $display("FAIL basic_reads: got %0d want 4", n_read - r0); end
        checks++;
        if (n_done - d0 != 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", n_done - d0); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_q.size() <= i || obs_q[i] !== exp_word(16'd2332, 16'd1, i)) begin
                errors++;
                $display("FAIL basic_word%0d: got %h want %h (count %0d)", i, (obs_q.size() > i) ? obs_q[i] : 16'hxxxx, exp_word(16'd2332, 16'd1, i), obs_q.size());
            end
        end
        tick();
        checks++;
        if (s_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end: busy=%b want 0", s_busy); end
    endtask

    task automatic test_stall();
        int r0, d0;
        bit seen;
        logic [15:0] b, s;
        b = 16'($urandom); s = 16'($urandom);
        r0 = n_read; d0 = n_done;
        pix_ready = 1'b0;
        start_scan(b, s, 16'd20);
        repeat (30) tick();
        checks++;
        if (n_read - r0 != DEPTH) begin errors++; $display("FAIL stall_reads: got %0d want %0d", n_read - r0, DEPTH); end
        checks++;
        if (!(s_valid && s_busy && !s_read)) begin
            errors++; $display("FAIL stall_state: valid=%b busy=%b read=%b want 1/1/0", s_valid, s_busy, s_read);
        end
        wait_done(400, 1'b1, seen);
        checks++;
        if (!seen) begin errors++; $display("FAIL stall_timeout: done not seen, want done"); end
        checks++;
        if (n_read - r0 != 20 || n_done - d0 != 1 || obs_q.size() != 20) begin
            errors++; $display("FAIL stall_totals: reads=%0d done=%0d words=%0d want 20/1/20", n_read - r0, n_done - d0, obs_q.size());
        end
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (obs_q.size() <= i || obs_q[i] !== exp_word(b, s, i)) begin
                errors++; $display("FAIL stall_word%0d: got %h want %h", i, (obs_q.size() > i) ? obs_q[i] : 16'hxxxx, exp_word(b, s, i));
            end
        end
        tick();
    endtask

    task automatic test_zero_count();
        int r0, a0;
        r0 = n_read; a0 = n_seta;
        start_scan(16'h1234, 16'd3, 16'd0);
        tick();
        checks++;
        if (!(s_done && s_busy && !s_seta && !s_incr && !s_read)) begin
            errors++; $display("FAIL zero_done: done=%b busy=%b strobes=%b%b%b want 1/1/000", s_done, s_busy, s_seta, s_incr, s_read);
        end
        tick();
        checks++;
        if (s_done !== 1'b0 || s_busy !== 1'b0 || n_read != r0 || n_seta != a0) begin
            errors++; $display("FAIL zero_after: done=%b busy=%b reads=%0d seta=%0d want 0/0/0/0", s_done, s_busy, n_read - r0, n_seta - a0);
        end
    endtask

    task automatic test_ignore_start();
        int a0, d0;
        bit seen;
        a0 = n_seta; d0 = n_done;
        pix_ready = 1'b1;
        start_scan(16'h0100, 16'd2, 16'd6);
        tick(); tick();
        start = 1'b1; base_addr = 16'h7000; stride = 16'd9; word_count = 16'd3;
        tick();
        start = 1'b0;
        wait_done(60, 1'b0, seen);
        checks++;
        if (!seen || n_seta - a0 != 1 || n_done - d0 != 1 || obs_q.size() != 6) begin
            errors++; $display("FAIL ignore_totals: done_seen=%b seta=%0d done=%0d words=%0d want 1/1/1/6", seen, n_seta - a0, n_done - d0, obs_q.size());
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (obs_q.size() <= i || obs_q[i] !== exp_word(16'h0100, 16'd2, i)) begin
                errors++; $display("FAIL ignore_word%0d: got %h want %h", i, (obs_q.size() > i) ? obs_q[i] : 16'hxxxx, exp_word(16'h0100, 16'd2, i));
            end
        end
        tick();
        checks++;
        if (s_busy !== 1'b0) begin errors++; $display("FAIL ignore_busy_end: busy=%b want 0", s_busy); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 5; n++) begin
            int r0;
            bit seen;
            logic [15:0] b, s, w;
            b = 16'($urandom); s = 16'($urandom); w = 16'($urandom_range(1, 24));
            r0 = n_read;
            start_scan(b, s, w);
            wait_done(600, 1'b1, seen);
            checks++;
            if (!seen || n_read - r0 != int'(w) || obs_q.size() != int'(w)) begin
                errors++; $display("FAIL random%0d_totals: seen=%b reads=%0d words=%0d want %0d", n, seen, n_read - r0, obs_q.size(), w);
            end
            for (int i = 0; i < int'(w); i++) begin
                checks++;
                if (obs_q.size() <= i || obs_q[i] !== exp_word(b, s, i)) begin
                    errors++; $display("FAIL random%0d_word%0d: got %h want %h", n, i, (obs_q.size() > i) ? obs_q[i] : 16'hxxxx, exp_word(b, s, i));
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_scan();
        bit seen;
        pix_ready = 1'b0;
        start_scan(16'h4000, 16'd4, 16'd16);
        repeat (6) tick();
        reset = 1'b0;
        tick();
        checks++;
        if ({s_seta, s_incr, s_read, s_valid, s_busy, s_done, s_under} !== 7'b0 || s_data !== 16'd0) begin
            errors++;
            $display("FAIL midreset_values: got flags=%b data=%h, want all 0", {s_seta, s_incr, s_read, s_valid, s_busy, s_done, s_under}, s_data);
        end
        reset = 1'b1;
        tick();
        pix_ready = 1'b1;
        start_scan(16'h0040, 16'd8, 16'd3);
        tick();
        checks++;
        if (!(s_seta && s_bus === 16'h0040)) begin
            errors++; $display("FAIL midreset_fresh_seta: seta=%b bus=%h want 1/0040", s_seta, s_bus);
        end
        wait_done(40, 1'b0, seen);
        checks++;
        if (!seen || obs_q.size() != 3) begin errors++; $display("FAIL midreset_fresh_totals: seen=%b words=%0d want 1/3", seen, obs_q.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs_q.size() <= i || obs_q[i] !== exp_word(16'h0040, 16'd8, i)) begin
                errors++; $display("FAIL midreset_word%0d: got %h want %h", i, (obs_q.size() > i) ? obs_q[i] : 16'hxxxx, exp_word(16'h0040, 16'd8, i));
            end
        end
        tick();
    endtask

    task automatic test_underrun();
        bit seen;
        pix_ready = 1'b1;
        start_scan(16'h0200, 16'd10, 16'd5);
        repeat (4) tick();
`ifdef VRAM_FETCH_UNDERRUN_EN
        checks++;
        if (s_under !== 1'b1) begin errors++; $display("FAIL underrun_set: underrun=%b want 1", s_under); end
`else
        checks++;
        if (s_under !== 1'b0) begin errors++; $display("FAIL underrun_disabled: underrun=%b want 0", s_under); end
`endif
        wait_done(40, 1'b0, seen);
        checks++;
        if (!seen) begin errors++; $display("FAIL underrun_timeout: done not seen, want done"); end
        tick();
        pix_ready = 1'b0;
        start_scan(16'h0300, 16'd1, 16'd2);
        tick();
        checks++;
        if (s_under !== 1'b0) begin errors++; $display("FAIL underrun_clear: underrun=%b want 0", s_under); end
        pix_ready = 1'b1;
        wait_done(40, 1'b0, seen);
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_zero_count();
        test_ignore_start();
        test_random();
        test_reset_mid_scan();
        test_underrun();
        checks++;
        if (n_overlap != 0) begin errors++; $display("FAIL strobe_exclusive: overlapping cycles=%0d want 0", n_overlap); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vram_scan_fetch.md
VRAM_SCAN_FETCH -- requirements
Module: vram_scan_fetch

Interface
REQ-001 Parameter DEPTH, default 8, prefetch FIFO depth in 16-bit words (power of two, 2..64).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle request to begin a scan; ignored while busy=1.
REQ-005 base_addr  input  16  first VRAM word address, sampled when start is accepted.
REQ-006 stride  input  16  address increment per read, sampled when start is accepted.
REQ-007 word_count  input  16  number of words to fetch, sampled when start is accepted.
REQ-008 data_bus_infr  inout  16  VRAM port-B shared bus; driven only as stated in REQ-014, else high-Z.
REQ-009 set_address_b, set_address_b_incr, read_b  output  1 each  VRAM port-B strobes.
REQ-010 pix_data  output  16  FIFO head word.
REQ-011 pix_valid  input-side handshake output  1  FIFO non-empty; pix_ready  input  1  consumer accepts.
REQ-012 busy  output  1  scan in progress; done  output  1  one-cycle completion pulse; underrun  output  1  sticky flag.

Function
REQ-013 FSM states: IDLE, SETA, SETI, READ, DRAIN; an accepted start moves IDLE->SETA, or IDLE->DRAIN if word_count=0.
REQ-014 SETA: set_address_b=1, bus driven with base_addr; SETI: set_address_b_incr=1, bus driven with stride; both last exactly one cycle each, SETA->SETI->READ.
REQ-015 READ: read_b=1 in a cycle only when FIFO count<DEPTH and remaining>0; bus is high-Z; bus word is written into the FIFO at the rising edge ending that cycle.
REQ-016 Remaining counter loads word_count on start and decrements by 1 per read_b cycle; READ->DRAIN when it reaches 0.
REQ-017 DRAIN: no strobes; when FIFO empty, done=1 for one cycle and FSM returns to IDLE.
REQ-018 Strobes are mutually exclusive; at most one is high in any cycle.
REQ-019 Minimum latency: start accepted at edge N; SETA in cycle N+1, SETI in N+2, first read_b in N+3, pix_valid=1 from cycle N+4.
REQ-020 pix_valid = (count!=0); a pop occurs on an edge where pix_valid and pix_ready are both 1; pix_data holds while pix_valid=1 and pix_ready=0.
REQ-021 Simultaneous push and pop in one cycle leaves count unchanged; push never occurs when full (REQ-015); pop when empty has no effect.
REQ-022 FIFO pointers wrap modulo DEPTH; count width holds 0..DEPTH.
REQ-023 busy=1 in every state except IDLE; start during busy=1 has no effect.
REQ-024 Address arithmetic resides in VRAM; this block performs no address computation and does not check 16-bit wrap.

Reset
REQ-025 Asserting reset at any time, including mid-scan, forces IDLE, releases data_bus_infr to high-Z and clears FIFO, counters and underrun.
REQ-026 Reset values: set_address_b=0, set_address_b_incr=0, read_b=0, pix_valid=0, pix_data=0, busy=0, done=0, underrun=0.

Configuration
REQ-027 Macro VRAM_FETCH_UNDERRUN_EN defined: underrun becomes 1 on the edge ending any cycle with busy=1, pix_ready=1 and pix_valid=0 in state READ; it stays 1 until reset or the next accepted start.
REQ-028 Macro VRAM_FETCH_UNDERRUN_EN not defined: underrun is constant 0 and no detection logic is built; all other behaviour is identical.

Verification
REQ-029 Reset low mid-READ with bus driven by no one -> all outputs at REQ-026 values, bus Z, next start behaves as a fresh scan.
REQ-030 base_addr=16'd2332, stride=1, word_count=4, pix_ready=1 -> bus carries 2332 in SETA and 1 in SETI, 4 read_b cycles starting N+3, 4 words out in order, then done pulse, busy=0.
REQ-031 DEPTH=8, word_count=20, pix_ready=0 -> exactly 8 read_b cycles then stall with pix_valid=1; raising pix_ready resumes reads, 20 words total, one done.
REQ-032 word_count=0 -> no strobes, done pulse one cycle after start acceptance, busy high for exactly that cycle.
REQ-033 Second start pulse while busy with different base_addr -> ignored; scan finishes with first parameters.
REQ-034 With VRAM_FETCH_UNDERRUN_EN, stride=10, pix_ready held 1 from start -> underrun=1 after first read cycle; next start clears it; without macro underrun stays 0.
